// File: rtl/pu_driver.sv
// pu_driver: operand sequencer and result collector for one 4-input
// dot-product processing unit. Latches an input vector on start, then for each
// neuron fetches a weight row, presents x/w operands to the PU, waits the PU
// latency, captures the result and offers it on a valid/ready stream.
// Optional feature macro: PU_DRIVER_RELU_EN (clamp negative results to zero).
module pu_driver #(
  parameter int N_NEURONS  = 4,
  parameter int IDX_W      = 8,
  parameter int PU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      x1_in,
  input  logic [31:0]      x2_in,
  input  logic [31:0]      x3_in,
  input  logic [31:0]      x4_in,
  output logic             w_rd,
  output logic [IDX_W-1:0] w_addr,
  input  logic [127:0]     w_data,
  output logic [31:0]      pu_x1,
  output logic [31:0]      pu_x2,
  output logic [31:0]      pu_x3,
  output logic [31:0]      pu_x4,
  output logic [31:0]      pu_w1,
  output logic [31:0]      pu_w2,
  output logic [31:0]      pu_w3,
  output logic [31:0]      pu_w4,
  input  logic [31:0]      pu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             busy,
  output logic             done
);

  // A combinational PU (latency 0) still gets one WAIT cycle.
  localparam int WAIT_CYC = (PU_LATENCY < 1) ? 1 : PU_LATENCY;
  localparam int CNT_W    = $clog2(WAIT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_rd_q, w_rd_d;
  logic [IDX_W-1:0] w_addr_q, w_addr_d;
  logic [31:0]      pu_x1_q, pu_x1_d, pu_x2_q, pu_x2_d, pu_x3_q, pu_x3_d, pu_x4_q, pu_x4_d;
  logic [31:0]      pu_w1_q, pu_w1_d, pu_w2_q, pu_w2_d, pu_w3_q, pu_w3_d, pu_w4_q, pu_w4_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Result capture path; with the ReLU feature a set sign bit forces zero.
  function automatic logic [31:0] capture_result(input logic [31:0] r);
`ifdef PU_DRIVER_RELU_EN
    return r[31] ? 32'h0000_0000 : r;
`else
    return r;
`endif
  endfunction

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    w_rd_d      = 1'b0;
    w_addr_d    = w_addr_q;
    pu_x1_d     = pu_x1_q;
    pu_x2_d     = pu_x2_q;
    pu_x3_d     = pu_x3_q;
    pu_x4_d     = pu_x4_q;
    pu_w1_d     = pu_w1_q;
    pu_w2_d     = pu_w2_q;
    pu_w3_d     = pu_w3_q;
    pu_w4_d     = pu_w4_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pu_x1_d  = x1_in;
          pu_x2_d  = x2_in;
          pu_x3_d  = x3_in;
          pu_x4_d  = x4_in;
          idx_d    = {IDX_W{1'b0}};
          w_rd_d   = 1'b1;
          w_addr_d = {IDX_W{1'b0}};
          busy_d   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          busy_d   = 1'b0;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        pu_w1_d = w_data[31:0];
        pu_w2_d = w_data[63:32];
        pu_w3_d = w_data[95:64];
        pu_w4_d = w_data[127:96];
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          out_data_d  = capture_result(pu_result);
          out_index_d = idx_q;
          out_valid_d = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = S_EMIT;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            w_rd_d   = 1'b1;
            w_addr_d = idx_q + IDX_W'(1);
            state_d  = S_FETCH;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= {IDX_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      w_rd_q      <= 1'b0;
      w_addr_q    <= {IDX_W{1'b0}};
      pu_x1_q     <= 32'h0;
      pu_x2_q     <= 32'h0;
      pu_x3_q     <= 32'h0;
      pu_x4_q     <= 32'h0;
      pu_w1_q     <= 32'h0;
      pu_w2_q     <= 32'h0;
      pu_w3_q     <= 32'h0;
      pu_w4_q     <= 32'h0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      out_index_q <= {IDX_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      w_rd_q      <= w_rd_d;
      w_addr_q    <= w_addr_d;
      pu_x1_q     <= pu_x1_d;
      pu_x2_q     <= pu_x2_d;
      pu_x3_q     <= pu_x3_d;
      pu_x4_q     <= pu_x4_d;
      pu_w1_q     <= pu_w1_d;
      pu_w2_q     <= pu_w2_d;
      pu_w3_q     <= pu_w3_d;
      pu_w4_q     <= pu_w4_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign w_rd      = w_rd_q;
  assign w_addr    = w_addr_q;
  assign pu_x1     = pu_x1_q;
  assign pu_x2     = pu_x2_q;
  assign pu_x3     = pu_x3_q;
  assign pu_x4     = pu_x4_q;
  assign pu_w1     = pu_w1_q;
  assign pu_w2     = pu_w2_q;
  assign pu_w3     = pu_w3_q;
  assign pu_w4     = pu_w4_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pu_driver.sv
// Directed bench for pu_driver. Instance a: 3 neurons, PU latency 2 (PU modelled
// as a dot product behind one register). Instance b: 3 neurons, combinational PU,
// with a mode that returns pu_w1 directly for the ReLU vectors.
module tb_pu_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  // free-running cycle counter used for period measurements
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dot4(input logic [31:0] x1, x2, x3, x4,
                                       input logic [31:0] w1, w2, w3, w4);
    return x1 * w1 + x2 * w2 + x3 * w3 + x4 * w4;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // ---------------- instance a ----------------
  logic        a_start = 1'b0, a_ready = 1'b1;
  logic [31:0] a_x1 = 32'h0, a_x2 = 32'h0, a_x3 = 32'h0, a_x4 = 32'h0;
  logic        a_w_rd, a_out_valid, a_busy, a_done;
  logic [7:0]  a_w_addr, a_out_index;
  logic [127:0] a_w_data = 128'h0;
  logic [31:0] a_px1, a_px2, a_px3, a_px4, a_pw1, a_pw2, a_pw3, a_pw4;
  logic [31:0] a_pu_result = 32'h0, a_out_data;
  logic [127:0] mem_a [0:2];

  pu_driver #(.N_NEURONS(3), .IDX_W(8), .PU_LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start),
    .x1_in(a_x1), .x2_in(a_x2), .x3_in(a_x3), .x4_in(a_x4),
    .w_rd(a_w_rd), .w_addr(a_w_addr), .w_data(a_w_data),
    .pu_x1(a_px1), .pu_x2(a_px2), .pu_x3(a_px3), .pu_x4(a_px4),
    .pu_w1(a_pw1), .pu_w2(a_pw2), .pu_w3(a_pw3), .pu_w4(a_pw4),
    .pu_result(a_pu_result), .out_valid(a_out_valid), .out_ready(a_ready),
    .out_data(a_out_data), .out_index(a_out_index), .busy(a_busy), .done(a_done)
  );

  // weight memory a (one-cycle read) and 2-cycle PU model
  always @(posedge clk) begin
    a_w_data    <= (a_w_rd && a_w_addr < 8'd3) ? mem_a[a_w_addr[1:0]] : {4{32'hDEAD_BEEF}};
    a_pu_result <= dot4(a_px1, a_px2, a_px3, a_px4, a_pw1, a_pw2, a_pw3, a_pw4);
  end

  // ---------------- instance b ----------------
  logic        b_start = 1'b0, b_ready = 1'b1, b_relu_mode = 1'b0;
  logic [31:0] b_x1 = 32'h0, b_x2 = 32'h0, b_x3 = 32'h0, b_x4 = 32'h0;
  logic        b_w_rd, b_out_valid, b_busy, b_done;
  logic [7:0]  b_w_addr, b_out_index;
  logic [127:0] b_w_data = 128'h0;
  logic [31:0] b_px1, b_px2, b_px3, b_px4, b_pw1, b_pw2, b_pw3, b_pw4;
  logic [31:0] b_pu_result, b_out_data;
  logic [127:0] mem_b [0:2];

  pu_driver #(.N_NEURONS(3), .IDX_W(8), .PU_LATENCY(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start),
    .x1_in(b_x1), .x2_in(b_x2), .x3_in(b_x3), .x4_in(b_x4),
    .w_rd(b_w_rd), .w_addr(b_w_addr), .w_data(b_w_data),
    .pu_x1(b_px1), .pu_x2(b_px2), .pu_x3(b_px3), .pu_x4(b_px4),
    .pu_w1(b_pw1), .pu_w2(b_pw2), .pu_w3(b_pw3), .pu_w4(b_pw4),
    .pu_result(b_pu_result), .out_valid(b_out_valid), .out_ready(b_ready),
    .out_data(b_out_data), .out_index(b_out_index), .busy(b_busy), .done(b_done)
  );

  always @(posedge clk)
    b_w_data <= (b_w_rd && b_w_addr < 8'd3) ? mem_b[b_w_addr[1:0]] : {4{32'hDEAD_BEEF}};
  assign b_pu_result = b_relu_mode ? b_pw1 : dot4(b_px1, b_px2, b_px3, b_px4, b_pw1, b_pw2, b_pw3, b_pw4);

  // ---------------- tasks ----------------
  task automatic wait_a_valid(output int n);
    n = 0;
    while (!a_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("a_valid_timeout", a_out_valid, 1'b1);
  endtask

  // One full pass on instance a with x=(1,2,3,4); optional start-while-busy
  // injection during WAIT of index 0 and backpressure on index 1.
  task automatic a_pass(input bit inject, input bit bp);
    logic [31:0] exp_d [3];
    int n, extra;
    exp_d[0] = 32'd10; exp_d[1] = 32'd2; exp_d[2] = 32'd20;
    @(negedge clk);
    a_x1 = 32'd1; a_x2 = 32'd2; a_x3 = 32'd3; a_x4 = 32'd4; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_x1 = 32'hFFFF_FFFF; a_x2 = 32'hFFFF_FFFF; a_x3 = 32'hFFFF_FFFF; a_x4 = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("a_fetch_rd", a_w_rd, 1'b1);
      check_eq("a_fetch_addr", a_w_addr, k);
      check_eq("a_busy", a_busy, 1'b1);
      if (k == 0) check_eq("a_pu_x1_latched", a_px1, 32'd1);
      if (bp && k == 1) a_ready = 1'b0;
      extra = 0;
      if (inject && k == 0) begin
        repeat (2) @(negedge clk);
        a_x1 = 32'd9; a_x2 = 32'd9; a_x3 = 32'd9; a_x4 = 32'd9; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        extra = 3;
      end
      wait_a_valid(n);
      check_eq("a_fetch_to_valid", n + extra, 4);
      check_eq("a_out_data", a_out_data, exp_d[k]);
      check_eq("a_out_index", a_out_index, k);
      if (bp && k == 1) begin
        for (int i = 1; i <= 7; i++) begin
          @(negedge clk);
          if (i < 7) check_eq("a_bp_hold", {a_out_valid, a_out_data, a_out_index, a_w_rd},
                              {1'b1, 32'd2, 8'd1, 1'b0});
        end
        check_eq("a_bp_no_fetch", a_w_rd, 1'b0);
        a_ready = 1'b1;
      end
    end
    @(negedge clk);
    check_eq("a_done_pulse", {a_done, a_busy, a_out_valid}, 3'b110);
    @(negedge clk);
    check_eq("a_done_clear", {a_done, a_busy}, 2'b00);
  endtask

  // One full pass on instance b; collects results and the FETCH period.
  task automatic b_pass(input logic [31:0] e0, e1, e2);
    logic [31:0] exp_d [3];
    int nv, nf, t, f0, f1;
    bit seen_done;
    exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2;
    nv = 0; nf = 0; f0 = 0; f1 = 0; seen_done = 1'b0;
    @(negedge clk);
    b_x1 = 32'd1; b_x2 = 32'd2; b_x3 = 32'd3; b_x4 = 32'd4; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    t = 0;
    while (!seen_done && t < 60) begin
      if (b_w_rd) begin
        if (nf == 0) f0 = cyc;
        if (nf == 1) f1 = cyc;
        nf++;
      end
      if (b_out_valid) begin
        if (nv < 3) begin
          check_eq("b_out_data", b_out_data, exp_d[nv]);
          check_eq("b_out_index", b_out_index, nv);
        end
        nv++;
      end
      if (b_done) seen_done = 1'b1;
      @(negedge clk);
      t++;
    end
    check_eq("b_done_seen", seen_done, 1'b1);
    check_eq("b_result_count", nv, 3);
    check_eq("b_fetch_period", f1 - f0, 4);
    check_eq("b_idle_after", b_busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [31:0] r0, r1, r2;
    mem_a[0] = {32'd1, 32'd1, 32'd1, 32'd1};
    mem_a[1] = {32'd0, 32'd0, 32'd0, 32'd2};
    mem_a[2] = {32'd5, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 3; i++) mem_b[i] = mem_a[i];

    repeat (3) @(negedge clk);
    check_eq("rst_a_outputs", {a_w_rd, a_out_valid, a_busy, a_done, a_w_addr, a_out_index},
             {4'b0000, 8'd0, 8'd0});
    check_eq("rst_a_data", {a_px1, a_pw4, a_out_data}, 96'h0);
    rst = 1'b0;

    // basic pass
    a_pass(1'b0, 1'b0);
    // backpressure on index 1
    a_pass(1'b0, 1'b1);
    // start while busy must be ignored
    a_pass(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("a_no_second_pass", {a_busy, a_out_valid, a_w_rd}, 3'b000);
    end
    check_eq("a_pu_x1_unchanged", a_px1, 32'd1);

    // reset mid-handshake
    a_ready = 1'b0;
    @(negedge clk);
    a_x1 = 32'd1; a_x2 = 32'd2; a_x3 = 32'd3; a_x4 = 32'd4; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_a_valid(n);
    repeat (2) @(negedge clk);
    check_eq("a_pre_rst_valid", a_out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("a_rst_ctrl", {a_out_valid, a_busy, a_done, a_w_rd, a_w_addr, a_out_index},
             {4'b0000, 8'd0, 8'd0});
    check_eq("a_rst_data", {a_out_data, a_px1, a_px4, a_pw1, a_pw4}, 160'h0);
    a_ready = 1'b1;
    a_pass(1'b0, 1'b0);

    // combinational PU
    b_pass(32'd10, 32'd2, 32'd20);

    // sign handling of captured results
    b_relu_mode = 1'b1;
    mem_b[0] = {96'h0, 32'hC0A0_0000};
    mem_b[1] = {96'h0, 32'h8000_0000};
    mem_b[2] = {96'h0, 32'h4000_0000};
`ifdef PU_DRIVER_RELU_EN
    r0 = 32'h0000_0000; r1 = 32'h0000_0000; r2 = 32'h4000_0000;
`else
    r0 = 32'hC0A0_0000; r1 = 32'h8000_0000; r2 = 32'h4000_0000;
`endif
    b_pass(r0, r1, r2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
